// File: rtl/data_memory_bam_responder_pkg.sv
// Shared definitions for the word-RAM load/store responder:
// FSM state encoding, legal lane-mask constants and small lane helpers.
package data_memory_bam_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BYTES_NONE = 4'b0000;
  localparam logic [3:0] BYTES_BYTE = 4'b0001;
  localparam logic [3:0] BYTES_HALF = 4'b0011;
  localparam logic [3:0] BYTES_WORD = 4'b1111;

  function automatic logic bytes_legal(input logic [3:0] b);
    return (b == BYTES_NONE) || (b == BYTES_BYTE) ||
           (b == BYTES_HALF) || (b == BYTES_WORD);
  endfunction

  // Expand a 4-bit lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes);
    logic [31:0] bits;
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{lanes[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/data_memory_bam_responder_if.sv
// Request/response bus between a requester (master) and the memory
// responder (slave); one request in flight at a time.
interface data_memory_bam_responder_if #(
  parameter int ADDR_W = 6
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W+1:0] req_addr;
  logic [3:0]        req_bytes;
  logic              req_wren;
  logic [31:0]       req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_bytes, req_wren, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_bytes, req_wren, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/data_memory_bam_responder_ram.sv
// Word RAM: ADDR_L x 32, one write port, registered read, contents
// survive reset.
module data_memory_bam_responder_ram #(
  parameter int ADDR_L = 64,
  parameter int ADDR_W = $clog2(ADDR_L)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata
);

  logic [31:0] mem [ADDR_L];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_memory_bam_responder.sv
// Load/store responder: accepts one byte/half/word request, reads the word
// RAM, then either returns shifted load data or read-modify-writes the word.
module data_memory_bam_responder
  import data_memory_bam_responder_pkg::*;
#(
  parameter int ADDR_L = 64,
  parameter int ADDR_W = $clog2(ADDR_L)
) (
  input logic                          clk,
  input logic                          rst_n,
  data_memory_bam_responder_if.slave   bus
);

  state_t            state_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic [31:0]       resp_data_reg;
  logic              resp_err_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [3:0]        bytes_reg;
  logic              wren_reg;
  logic [31:0]       data_reg;

  logic              accept;
  logic [1:0]        off;
  logic [7:0]        emask_wide;
  logic [31:0]       emask_bits;
  logic              misaligned;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic              ram_we;

  assign accept = bus.req_valid & req_ready_reg;

  // The RAM read is launched on the acceptance edge so the word is ready in READ.
  data_memory_bam_responder_ram #(
    .ADDR_L (ADDR_L),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .re    (accept),
    .raddr (bus.req_addr[ADDR_W+1:2]),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (addr_reg[ADDR_W+1:2]),
    .wdata (merged)
  );

  assign off        = addr_reg[1:0];
  assign emask_wide = {4'b0000, bytes_reg} << off;
  // Any lane pushed past lane 3 means the access straddles a word.
  assign misaligned = !bytes_legal(bytes_reg) || (emask_wide[7:4] != 4'b0000);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign emask_bits[8*gi +: 8] = {8{emask_wide[gi]}};
    end
  endgenerate

  assign load_data = (ram_rdata >> {off, 3'b000}) & lanes_to_bits(bytes_reg);
  assign merged    = ((data_reg << {off, 3'b000}) & emask_bits) | (ram_rdata & ~emask_bits);
  // Gating with rst_n drops a store whose READ cycle is hit by reset.
  assign ram_we    = rst_n && (state_reg == ST_READ) && wren_reg &&
                     !misaligned && (bytes_reg != BYTES_NONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
      addr_reg       <= '0;
      bytes_reg      <= '0;
      wren_reg       <= 1'b0;
      data_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg      <= bus.req_addr;
            bytes_reg     <= bus.req_bytes;
            wren_reg      <= bus.req_wren;
            data_reg      <= bus.req_data;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_READ;
          end
        end
        ST_READ: begin
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= misaligned;
          resp_data_reg  <= (misaligned || wren_reg) ? 32'h0 : load_data;
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule
